// File: rtl/uart_axil_rd_slave_pkg.sv
// uart_axil_pkg: shared definitions for the AXI-Lite-to-UART bridge read path.
// Contents: register offsets, AXI response codes, read FSM states, and the
// bit positions used in the STATUS, CTRL and RX_DATA registers.
package uart_axil_pkg;

   // Register offsets, decoded from araddr[3:0]
   localparam logic [3:0] UART_RX_DATA = 4'h0;
   localparam logic [3:0] UART_TX_DATA = 4'h4;
   localparam logic [3:0] UART_STATUS  = 4'h8;
   localparam logic [3:0] UART_CTRL    = 4'hC;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {IDLE, RESP} rd_state_e;

   // STATUS bit positions
   localparam int ST_RX_AVAIL = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_EMPTY = 2;
   localparam int ST_TX_FULL  = 3;
   localparam int ST_OVERRUN  = 4;

   // CTRL bit positions
   localparam int CTRL_RX_IE  = 0;
   localparam int CTRL_OVR_IE = 1;

   // RX_DATA "byte present" flag
   localparam int RX_VALID_BIT = 31;

endpackage

// File: rtl/uart_axil_rd_slave_if.sv
// uart_axil_rd_if: AXI-Lite read channel (AR + R) for the UART bridge.
// Signals: araddr, arvalid, arready (AR); rdata, rresp, rvalid, rready (R).
// master modport drives AR and rready; slave modport drives arready and R.
interface uart_axil_rd_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_RESP_WIDTH = 2
);
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic [AXI_RESP_WIDTH-1:0] rresp;
   logic                      rvalid;
   logic                      rready;

   modport master (output araddr, arvalid, rready,
                   input  arready, rdata, rresp, rvalid);
   modport slave  (input  araddr, arvalid, rready,
                   output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/uart_axil_rd_slave_irq.sv
// uart_irq_gen: sticky RX overrun flag and the registered UART interrupt.
// Ports: clk/rst (async, active-high); rx_push_i, rx_full_i set overrun;
// ovr_clr_i clears it (a set in the same cycle wins); rx_empty_i and the two
// enables feed uart_irq, which lags its sources by one cycle.
module uart_irq_gen (
   input  logic clk,
   input  logic rst,
   input  logic rx_push_i,
   input  logic rx_full_i,
   input  logic ovr_clr_i,
   input  logic rx_empty_i,
   input  logic rx_ie_i,
   input  logic ovr_ie_i,
   output logic overrun_o,
   output logic uart_irq
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_o <= 1'b0;
         uart_irq  <= 1'b0;
      end else begin
         overrun_o <= (rx_push_i & rx_full_i) | (overrun_o & ~ovr_clr_i);
         uart_irq  <= (~rx_empty_i & rx_ie_i) | (overrun_o & ovr_ie_i);
      end
   end
endmodule

// File: rtl/uart_axil_rd_slave.sv
// uart_axil_rd_slave: AXI-Lite read responder for the UART bridge.
// Ports: clk, rst (async, active-high); s_axi (read channel, slave modport);
// rx_data_i/rx_empty_i/rx_full_i/rx_push_i from the RX FIFO and receiver,
// rx_pop_o one-cycle pop pulse; tx_empty_i/tx_full_i TX FIFO status;
// ctrl_i control register; uart_irq registered interrupt.
// The response (rdata/rresp) and side effects (pop, overrun clear) are
// decoded combinationally from araddr and committed on the AR handshake.
module uart_axil_rd_slave
   import uart_axil_pkg::*;
#(
   parameter int                      AXI_ADDR_WIDTH = 32,
   parameter int                      AXI_DATA_WIDTH = 32,
   parameter int                      AXI_RESP_WIDTH = 2,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
   input  logic        clk,
   input  logic        rst,
   uart_axil_rd_if.slave s_axi,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_empty_i,
   input  logic        rx_full_i,
   input  logic        rx_push_i,
   output logic        rx_pop_o,
   input  logic        tx_empty_i,
   input  logic        tx_full_i,
   input  logic [31:0] ctrl_i,
   output logic        uart_irq
);
   rd_state_e                 state, state_nxt;
   logic                      arready_q, rvalid_q, arready_d, rvalid_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, dec_data;
   logic [AXI_RESP_WIDTH-1:0] rresp_q, dec_resp;
   logic                      dec_pop, dec_ovr_clr;
   logic                      ar_hs, r_hs, overrun;
   logic [31:0]               status_w;

   assign ar_hs = s_axi.arvalid & arready_q;
   assign r_hs  = rvalid_q & s_axi.rready;

   // Address decode
   always_comb begin
      status_w              = '0;
      status_w[ST_RX_AVAIL] = ~rx_empty_i;
      status_w[ST_RX_FULL]  = rx_full_i;
      status_w[ST_TX_EMPTY] = tx_empty_i;
      status_w[ST_TX_FULL]  = tx_full_i;
      status_w[ST_OVERRUN]  = overrun;   // pre-clear value is what gets returned

      dec_data    = '0;
      dec_resp    = AXI_RESP_WIDTH'(RESP_OKAY);
      dec_pop     = 1'b0;
      dec_ovr_clr = 1'b0;
      if (s_axi.araddr[AXI_ADDR_WIDTH-1:4] != BASE_ADDR[AXI_ADDR_WIDTH-1:4]) begin
         dec_resp = AXI_RESP_WIDTH'(RESP_DECERR);
      end else if (s_axi.araddr[1:0] != 2'b00) begin
         dec_resp = AXI_RESP_WIDTH'(RESP_SLVERR);
      end else begin
         case (s_axi.araddr[3:0])
            UART_RX_DATA: if (!rx_empty_i) begin
               dec_data = AXI_DATA_WIDTH'({1'b1, 23'd0, rx_data_i});
               dec_pop  = 1'b1;
            end
            UART_STATUS: begin
               dec_data    = AXI_DATA_WIDTH'(status_w);
               dec_ovr_clr = 1'b1;
            end
            UART_CTRL: dec_data = AXI_DATA_WIDTH'(ctrl_i);
            default:   ;  // TX_DATA is write-only: reads return 0, OKAY
         endcase
      end
   end

   // FSM next state; arready/rvalid are registered copies of the next state,
   // so arready stays low for the first cycle after reset release.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ar_hs) state_nxt = RESP;
         RESP:    if (r_hs)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      arready_d = (state_nxt == IDLE);
      rvalid_d  = (state_nxt == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rx_pop_o  <= 1'b0;
      end else begin
         state     <= state_nxt;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rx_pop_o  <= ar_hs & dec_pop;
         if (ar_hs) begin
            rdata_q <= dec_data;
            rresp_q <= dec_resp;
         end
      end
   end

   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;

   uart_irq_gen u_irq (
      .clk        (clk),
      .rst        (rst),
      .rx_push_i  (rx_push_i),
      .rx_full_i  (rx_full_i),
      .ovr_clr_i  (ar_hs & dec_ovr_clr),
      .rx_empty_i (rx_empty_i),
      .rx_ie_i    (ctrl_i[CTRL_RX_IE]),
      .ovr_ie_i   (ctrl_i[CTRL_OVR_IE]),
      .overrun_o  (overrun),
      .uart_irq   (uart_irq)
   );
endmodule

// File: tb/tb_uart_axil_rd_slave.sv
// Bench for uart_axil_rd_slave: scenario tasks drive AR/R traffic, expected
// responses go into a scoreboard queue at AR time and are compared when the
// R handshake happens. A small RX FIFO model feeds rx_data_i/rx_empty_i.
module tb_uart_axil_rd_slave;
   import uart_axil_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_axil_rd_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_RESP_WIDTH(2)) s_axi ();

   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_empty_i = 1'b1;
   logic        rx_full_i, rx_push_i, rx_pop_o, tx_empty_i, tx_full_i, uart_irq;
   logic [31:0] ctrl_i;

   uart_axil_rd_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
                        .AXI_RESP_WIDTH(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .s_axi(s_axi),
      .rx_data_i(rx_data_i), .rx_empty_i(rx_empty_i), .rx_full_i(rx_full_i),
      .rx_push_i(rx_push_i), .rx_pop_o(rx_pop_o), .tx_empty_i(tx_empty_i),
      .tx_full_i(tx_full_i), .ctrl_i(ctrl_i), .uart_irq(uart_irq)
   );

   typedef struct { logic [31:0] d; logic [1:0] r; } exp_t;
   exp_t       sb[$];
   logic [7:0] rx_q[$];
   int         pop_cnt = 0;
   int         total = 0;
   int         bad = 0;

   // RX FIFO model, updated away from the active edge
   always @(negedge clk) begin
      if (rx_pop_o === 1'b1) begin
         pop_cnt++;
         if (rx_q.size() > 0) void'(rx_q.pop_front());
      end
      rx_empty_i = (rx_q.size() == 0);
      rx_data_i  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic fifo_put(input logic [7:0] b);
      rx_q.push_back(b);
      @(negedge clk);
      tick();
   endtask

   task automatic expect_rd(input logic [31:0] d, input logic [1:0] r);
      exp_t e;
      e.d = d; e.r = r;
      sb.push_back(e);
   endtask

   // Drive AR until accepted; on return we are in cycle N+1
   task automatic ar_send(input logic [31:0] a, input logic exp_pop, input string nm);
      bit hs = 0;
      s_axi.araddr  = a;
      s_axi.arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (s_axi.arready === 1'b1) begin
            tick(); hs = 1; break;
         end
         tick();
      end
      s_axi.arvalid = 1'b0;
      total++;
      if (!hs) begin
         bad++; $display("FAIL %s ar_accept: arready never seen", nm);
      end
      total++;
      if (s_axi.rvalid !== 1'b1 || rx_pop_o !== exp_pop) begin
         bad++;
         $display("FAIL %s latency: rvalid=%b pop=%b, want rvalid=1 pop=%b",
                  nm, s_axi.rvalid, rx_pop_o, exp_pop);
      end
   endtask

   // Hold rready low 'hold' cycles, then complete R and check the scoreboard
   task automatic r_recv(input int hold, input string nm);
      logic [31:0] d0;
      logic [1:0]  r0;
      exp_t        e;
      s_axi.rready = 1'b0;
      d0 = s_axi.rdata;
      r0 = s_axi.rresp;
      for (int i = 0; i < hold; i++) begin
         total++;
         if (s_axi.rvalid !== 1'b1 || s_axi.arready !== 1'b0 ||
             s_axi.rdata !== d0 || s_axi.rresp !== r0) begin
            bad++;
            $display("FAIL %s hold%0d: rvalid=%b arready=%b rdata=%h rresp=%b, want 1/0/%h/%b",
                     nm, i, s_axi.rvalid, s_axi.arready, s_axi.rdata, s_axi.rresp, d0, r0);
         end
         tick();
      end
      s_axi.rready = 1'b1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL %s data: scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== e.d || s_axi.rresp !== e.r) begin
            bad++;
            $display("FAIL %s data: rvalid=%b rdata=%h rresp=%b, want 1/%h/%b",
                     nm, s_axi.rvalid, s_axi.rdata, s_axi.rresp, e.d, e.r);
         end
      end
      tick();
      s_axi.rready = 1'b0;
      total++;
      if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1 || rx_pop_o !== 1'b0) begin
         bad++;
         $display("FAIL %s after: rvalid=%b arready=%b pop=%b, want 0/1/0",
                  nm, s_axi.rvalid, s_axi.arready, rx_pop_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_axi.arvalid = 0; s_axi.rready = 0; s_axi.araddr = '0;
      ctrl_i = '0; tx_empty_i = 1; tx_full_i = 0; rx_full_i = 0; rx_push_i = 0;
      repeat (3) tick();
      total++;
      if (s_axi.arready !== 0 || s_axi.rvalid !== 0 || s_axi.rdata !== 0 ||
          s_axi.rresp !== 0 || rx_pop_o !== 0 || uart_irq !== 0) begin
         bad++;
         $display("FAIL reset_vals: arready=%b rvalid=%b rdata=%h rresp=%b pop=%b irq=%b, want all 0",
                  s_axi.arready, s_axi.rvalid, s_axi.rdata, s_axi.rresp, rx_pop_o, uart_irq);
      end
      rst = 1'b0;
      total++;
      if (s_axi.arready !== 0) begin
         bad++; $display("FAIL reset_release: arready=%b want 0", s_axi.arready);
      end
      tick();
      total++;
      if (s_axi.arready !== 1 || s_axi.rvalid !== 0) begin
         bad++; $display("FAIL arready_rise: arready=%b rvalid=%b want 1/0", s_axi.arready, s_axi.rvalid);
      end
      ctrl_i = 32'h3;
      expect_rd(32'h3, RESP_OKAY);
      ar_send(32'hC, 1'b0, "ctrl_rd");
      r_recv(0, "ctrl_rd");
      ctrl_i = 32'h0;
   endtask

   task automatic test_rx_data();
      int p0;
      fifo_put(8'hA5);
      p0 = pop_cnt;
      expect_rd(32'h8000_00A5, RESP_OKAY);
      ar_send(32'h0, 1'b1, "rx_a5");
      r_recv(0, "rx_a5");
      total++;
      if (pop_cnt != p0 + 1 || rx_q.size() != 0) begin
         bad++; $display("FAIL rx_single_pop: pops=%0d left=%0d want 1/0", pop_cnt - p0, rx_q.size());
      end
      p0 = pop_cnt;
      expect_rd(32'h0, RESP_OKAY);
      ar_send(32'h0, 1'b0, "rx_empty");
      r_recv(0, "rx_empty");
      total++;
      if (pop_cnt != p0) begin
         bad++; $display("FAIL rx_empty_nopop: pops=%0d want 0", pop_cnt - p0);
      end
   endtask

   task automatic test_back_to_back();
      ctrl_i = 32'hCAFE_0000;
      expect_rd(32'hCAFE_0000, RESP_OKAY);
      ar_send(32'hC, 1'b0, "bp_ctrl");
      // New request held by the master while the response is stalled
      s_axi.araddr  = 32'h4;
      s_axi.arvalid = 1'b1;
      expect_rd(32'h0, RESP_OKAY);
      r_recv(5, "bp_ctrl");
      tick();   // held AR is accepted at the first edge with arready high
      s_axi.arvalid = 1'b0;
      total++;
      if (s_axi.rvalid !== 1'b1) begin
         bad++; $display("FAIL bp_next_accept: rvalid=%b want 1", s_axi.rvalid);
      end
      r_recv(0, "bp_tx");
      ctrl_i = 32'h0;
   endtask

   task automatic test_overrun();
      rx_push_i = 1; rx_full_i = 1;
      tick();
      rx_push_i = 0; rx_full_i = 0;
      ctrl_i = 32'h2;
      tick();
      total++;
      if (uart_irq !== 1'b1) begin
         bad++; $display("FAIL ovr_irq: irq=%b want 1", uart_irq);
      end
      ctrl_i = 32'h0;
      expect_rd(32'h14, RESP_OKAY);
      ar_send(32'h8, 1'b0, "ovr_set");
      r_recv(0, "ovr_set");
      expect_rd(32'h04, RESP_OKAY);
      ar_send(32'h8, 1'b0, "ovr_clr");
      r_recv(0, "ovr_clr");
      // push-on-full in the same cycle as the STATUS accept
      total++;
      if (s_axi.arready !== 1'b1) begin
         bad++; $display("FAIL ovr_race_ready: arready=%b want 1", s_axi.arready);
      end
      s_axi.araddr = 32'h8; s_axi.arvalid = 1; rx_push_i = 1; rx_full_i = 1;
      expect_rd(32'h06, RESP_OKAY);
      tick();
      s_axi.arvalid = 0; rx_push_i = 0; rx_full_i = 0;
      r_recv(0, "ovr_race");
      expect_rd(32'h14, RESP_OKAY);
      ar_send(32'h8, 1'b0, "ovr_setwins");
      r_recv(0, "ovr_setwins");
      expect_rd(32'h04, RESP_OKAY);
      ar_send(32'h8, 1'b0, "ovr_clr2");
      r_recv(0, "ovr_clr2");
   endtask

   task automatic test_errors();
      int p0;
      fifo_put(8'h5A);
      p0 = pop_cnt;
      expect_rd(32'h0, RESP_DECERR);
      ar_send(32'h20, 1'b0, "decerr");
      r_recv(0, "decerr");
      expect_rd(32'h0, RESP_SLVERR);
      ar_send(32'h6, 1'b0, "slverr");
      r_recv(0, "slverr");
      total++;
      if (pop_cnt != p0 || rx_q.size() != 1) begin
         bad++; $display("FAIL err_nopop: pops=%0d left=%0d want 0/1", pop_cnt - p0, rx_q.size());
      end
      expect_rd(32'h8000_005A, RESP_OKAY);
      ar_send(32'h0, 1'b1, "rx_5a");
      r_recv(0, "rx_5a");
   endtask

   task automatic test_irq_reset();
      int p0;
      ctrl_i = 32'h1;
      rx_q.push_back(8'h11);
      @(negedge clk); #1;
      total++;
      if (uart_irq !== 1'b0) begin
         bad++; $display("FAIL irq_lag: irq=%b want 0", uart_irq);
      end
      tick();
      total++;
      if (uart_irq !== 1'b1) begin
         bad++; $display("FAIL irq_rx: irq=%b want 1", uart_irq);
      end
      rx_push_i = 1; rx_full_i = 1;
      tick();
      rx_push_i = 0; rx_full_i = 0;
      p0 = pop_cnt;
      expect_rd(32'h8000_0011, RESP_OKAY);
      ar_send(32'h0, 1'b1, "rst_rd");
      rst = 1'b1;
      #1;
      total++;
      if (s_axi.rvalid !== 0 || uart_irq !== 0 || rx_pop_o !== 0 || s_axi.arready !== 0) begin
         bad++;
         $display("FAIL rst_async: rvalid=%b irq=%b pop=%b arready=%b, want all 0",
                  s_axi.rvalid, uart_irq, rx_pop_o, s_axi.arready);
      end
      sb.delete();
      tick();
      rst = 1'b0;
      tick();
      total++;
      if (pop_cnt != p0 || rx_q.size() != 1) begin
         bad++; $display("FAIL rst_nopop: pops=%0d left=%0d want 0/1", pop_cnt - p0, rx_q.size());
      end
      ctrl_i = 32'h0;
      expect_rd(32'h05, RESP_OKAY);
      ar_send(32'h8, 1'b0, "rst_ovr");
      r_recv(0, "rst_ovr");
      expect_rd(32'h8000_0011, RESP_OKAY);
      ar_send(32'h0, 1'b1, "rst_drain");
      r_recv(0, "rst_drain");
   endtask

   initial begin
      test_reset();
      test_rx_data();
      test_back_to_back();
      test_overrun();
      test_errors();
      test_irq_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
